// File: rtl/rs232_rx_fifo_if.sv
// rs232_rx_fifo_if: bundle of the receive-buffer signals between the RS232R
// receiver, the CPU IO read path and the rs232_rx_fifo block.
//   rx_rdy/rx_data/rx_done : byte handshake with RS232R
//   rd/dout/rdy/full/count : CPU data port (word 2) and occupancy
//   ovf/clr_ovf            : sticky overflow flag and its clear
//   rts_n                  : hardware flow control, only with RX_FIFO_RTS_EN
// The slave modport is the FIFO side, the master modport the surrounding system.
interface rs232_rx_fifo_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          rx_rdy;
  logic [DW-1:0] rx_data;
  logic          rx_done;
  logic          rd;
  logic [DW-1:0] dout;
  logic          rdy;
  logic          full;
  logic [AW:0]   count;
  logic          ovf;
  logic          clr_ovf;
`ifdef RX_FIFO_RTS_EN
  logic          rts_n;
`endif

  modport slave (
    input  rx_rdy, rx_data, rd, clr_ovf,
`ifdef RX_FIFO_RTS_EN
    output rts_n,
`endif
    output rx_done, dout, rdy, full, count, ovf
  );

  modport master (
    output rx_rdy, rx_data, rd, clr_ovf,
`ifdef RX_FIFO_RTS_EN
    input  rts_n,
`endif
    input  rx_done, dout, rdy, full, count, ovf
  );
endinterface

// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: receive buffer between RS232R and the CPU IO bus.
// Drains RS232R one byte per rdy assertion (acknowledged with a one-cycle
// rx_done), stores bytes in a 2**AW-entry first-word-fall-through FIFO and
// presents them to the CPU at its own pace.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   bus     : rs232_rx_fifo_if.slave (rx_rdy, rx_data, rx_done, rd, dout,
//             rdy, full, count, ovf, clr_ovf [, rts_n])
// Optional feature macro: RX_FIFO_RTS_EN adds registered rts_n flow control
// with hysteresis (assert at count >= depth-4, release at count <= depth/2).
module rs232_rx_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic clk,
  input  logic rst,
  rs232_rx_fifo_if.slave bus
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state;
  logic          rx_done;
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf;

  logic          is_empty;
  logic          is_full;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  assign is_empty = (count == '0);
  assign is_full  = (count == DEPTH);
  // A byte is offered only once per rdy assertion: only IDLE samples rx_rdy.
  assign push_req = (state == IDLE) && bus.rx_rdy;
  // Popping an empty FIFO is silently ignored.
  assign pop      = bus.rd && !is_empty;
  // When full, a simultaneous pop frees the slot the push needs.
  assign push_ok  = push_req && (!is_full || bus.rd);

  // Capture FSM; rx_done is registered and high only while in ACK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rx_done <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: if (bus.rx_rdy) begin
          state   <= ACK;
          rx_done <= 1'b1;
        end
        ACK:  state <= WAIT;
        // Wait for RS232R to drop rdy so a late clear is not a second byte.
        WAIT: if (!bus.rx_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + (AW+1)'(1);
      else if (!push_ok && pop) count <= count - (AW+1)'(1);
      // A dropped byte outranks a clear in the same cycle.
      if (push_req && !push_ok) ovf <= 1'b1;
      else if (bus.clr_ovf)     ovf <= 1'b0;
    end
  end

  // Storage is not reset; dout masks it while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.rx_data;
  end

`ifdef RX_FIFO_RTS_EN
  logic rts_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rts_n <= 1'b0;
    end else if (count >= DEPTH - (AW+1)'(4)) begin
      rts_n <= 1'b1;
    end else if (count <= (DEPTH >> 1)) begin
      rts_n <= 1'b0;
    end
  end

  assign bus.rts_n = rts_n;
`endif

  assign bus.rx_done = rx_done;
  assign bus.dout    = is_empty ? '0 : mem[rd_ptr];
  assign bus.rdy     = !is_empty;
  assign bus.full    = is_full;
  assign bus.count   = count;
  assign bus.ovf     = ovf;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Testbench for rs232_rx_fifo: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a queue model.
module tb_rs232_rx_fifo;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rs232_rx_fifo_if #(.AW(AW), .DW(DW)) bus();
  rs232_rx_fifo #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue, a one-shot capture per rdy assertion,
  // and a sticky overflow flag.
  logic [7:0] mq[$];
  int         mphase = 0;   // 0 ready for a byte, 1 acknowledging, 2 waiting for rdy low
  bit         mdone  = 0;
  bit         movf   = 0;
  bit         mrts   = 0;

  always @(posedge clk) begin : model_cmp
    bit take;
    bit rem;
    int sz;
    if (!rst) begin
      mq.delete();
      mphase = 0;
      mdone  = 0;
      movf   = 0;
      mrts   = 0;
    end else begin
      sz = mq.size();
      if (sz >= DEPTH - 4)      mrts = 1;
      else if (sz <= DEPTH / 2) mrts = 0;
      take  = (mphase == 0) && bus.rx_rdy;
      rem   = bus.rd && (sz > 0);
      mdone = take;
      if (mphase == 0)      begin if (bus.rx_rdy) mphase = 1; end
      else if (mphase == 1) mphase = 2;
      else if (!bus.rx_rdy) mphase = 0;
      if (rem) void'(mq.pop_front());
      if (take && !(sz < DEPTH || rem)) movf = 1;
      else if (bus.clr_ovf)             movf = 0;
      if (take && (sz < DEPTH || rem)) mq.push_back(bus.rx_data);
    end
    #2;
    chk("rx_done", bus.rx_done, mdone);
    chk("count",   bus.count,   mq.size());
    chk("rdy",     bus.rdy,     mq.size() > 0);
    chk("full",    bus.full,    mq.size() == DEPTH);
    chk("ovf",     bus.ovf,     movf);
    chk("dout",    bus.dout,    (mq.size() > 0) ? mq[0] : 8'h00);
`ifdef RX_FIFO_RTS_EN
    chk("rts_n",   bus.rts_n,   mrts);
`endif
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic with_rd);
    int n;
    n = 0;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    bus.rd      = with_rd;
    tick();
    bus.rd = 1'b0;
    while (bus.rx_done !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("send_ack", bus.rx_done, 1);
    bus.rx_rdy = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk(name, bus.dout, exp);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rx_rdy  = 1'b0;
    bus.rx_data = '0;
    bus.rd      = 1'b0;
    bus.clr_ovf = 1'b0;
    tick();
    tick();
    chk("reset_rdy",   bus.rdy,     0);
    chk("reset_count", bus.count,   0);
    chk("reset_dout",  bus.dout,    0);
    chk("reset_done",  bus.rx_done, 0);
    rst = 1'b1;
    tick();

    // Single byte: ack the cycle after the push, visible the same cycle.
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h41;
    tick();
    chk("t1_done",  bus.rx_done, 1);
    chk("t1_rdy",   bus.rdy,     1);
    chk("t1_count", bus.count,   1);
    chk("t1_dout",  bus.dout,    8'h41);
    bus.rx_rdy = 1'b0;
    tick();
    chk("t1_done_once", bus.rx_done, 0);
    tick();
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    chk("t1_rdy_after_rd",  bus.rdy,  0);
    chk("t1_dout_after_rd", bus.dout, 0);

    // Fill, drain and wrap.
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    chk("t2_full",  bus.full,  1);
    chk("t2_count", bus.count, 16);
    chk("t2_ovf",   bus.ovf,   0);
    for (int i = 0; i < 16; i++) pop_chk("t2_drain", 8'(i));
    chk("t2_empty", bus.rdy, 0);
    for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) pop_chk("t2_wrap", 8'hA0 + 8'(i));

    // Overflow.
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    send(8'hEE, 1'b0);
    chk("t3_count", bus.count, 16);
    chk("t3_ovf",   bus.ovf,   1);
    chk("t3_head",  bus.dout,  8'h00);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("t3_clr", bus.ovf, 0);
    bus.clr_ovf = 1'b1;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'hEE;
    tick();
    bus.clr_ovf = 1'b0;
    chk("t3_set_wins", bus.ovf, 1);
    bus.rx_rdy = 1'b0;
    tick();
    tick();

    // Full with simultaneous read: the push lands.
    send(8'h5A, 1'b1);
    chk("t4_count", bus.count, 16);
    for (int i = 1; i < 16; i++) pop_chk("t4_drain", 8'(i));
    pop_chk("t4_last", 8'h5A);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;

    // Stuck rx_rdy.
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h77;
    tick();
    chk("t5_done", bus.rx_done, 1);
    repeat (10) tick();
    chk("t5_single_push", bus.count,   1);
    chk("t5_no_done",     bus.rx_done, 0);
    bus.rx_rdy = 1'b0;
    tick();
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h78;
    tick();
    chk("t5_done2",  bus.rx_done, 1);
    chk("t5_count2", bus.count,   2);
    bus.rx_rdy = 1'b0;
    tick();
    tick();
    pop_chk("t5_pop1", 8'h77);
    pop_chk("t5_pop2", 8'h78);

    // Asynchronous reset with count=5 and the FSM in ACK.
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h55;
    tick();
    chk("t6_pre_done",  bus.rx_done, 1);
    chk("t6_pre_count", bus.count,   5);
    #2;
    rst        = 1'b0;
    bus.rx_rdy = 1'b0;
    #1;
    chk("t6_done",  bus.rx_done, 0);
    chk("t6_rdy",   bus.rdy,     0);
    chk("t6_count", bus.count,   0);
    chk("t6_ovf",   bus.ovf,     0);
    tick();
    rst = 1'b1;
    tick();
    send(8'h3C, 1'b0);
    chk("t6_after_count", bus.count, 1);
    chk("t6_after_dout",  bus.dout,  8'h3C);
`ifdef RX_FIFO_RTS_EN
    for (int i = 0; i < 11; i++) send(8'(i), 1'b0);
    chk("rts_at_12", bus.rts_n, 1);
    for (int i = 0; i < 4; i++) begin
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
    end
    chk("rts_hold_8", bus.rts_n, 1);
    tick();
    chk("rts_rel_8", bus.rts_n, 0);
`endif

    // Randomized traffic with varying read pressure.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        bus.rx_rdy  = ($urandom_range(0, 2) != 0);
        bus.rx_data = 8'($urandom_range(0, 255));
        case (ph)
          0:       bus.rd = ($urandom_range(0, 7) == 0);
          1:       bus.rd = ($urandom_range(0, 1) == 1);
          default: bus.rd = ($urandom_range(0, 3) == 0);
        endcase
        bus.clr_ovf = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    bus.rx_rdy  = 1'b0;
    bus.rd      = 1'b0;
    bus.clr_ovf = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs232_rx_fifo.md
Name: rs232_rx_fifo

Overview:
Receive buffer between the RS232R receiver and the CPU IO read path at IO word address 2 (data) and 3 (status). It drains RS232R whenever a byte is ready, acknowledging with RS232R's done input, and stores the byte in a small FIFO. The CPU reads bytes at its own pace, so bursts at 115200 baud are not lost during long Oberon disk or display operations. Status bits replace the raw rdyRx on the IO bus.

Parameters:
AW, 4, FIFO address width; depth = 2**AW entries (16).
DW, 8, data width.

Ports:
clk  in  1  system clock (25 MHz CPU clock)
rst  in  1  asynchronous active-low reset
rx_rdy  in  1  RS232R rdy: byte valid, held until done
rx_data  in  DW  RS232R data
rx_done  out  1  one-cycle acknowledge to RS232R done
rd  in  1  CPU read strobe (rd & ioenb & iowadr==2); pops one entry
dout  out  DW  head entry (first-word-fall-through); 0 when empty
rdy  out  1  FIFO not empty
full  out  1  count == 2**AW
count  out  AW+1  occupancy, 0..2**AW
ovf  out  1  sticky overflow flag
clr_ovf  in  1  clears ovf (CPU write to status address with bit 0 = 1)

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=rd_ptr=0, count=0, ovf=0, rx_done=0, FSM=IDLE. Outputs: rdy=0, full=0, dout=0. Storage array content is not reset.
- Pointers are AW bits and wrap modulo 2**AW. count is a separate AW+1-bit register.
- Capture FSM, one byte per RS232R rdy assertion. States:
  - IDLE: when rx_rdy=1, push rx_data (subject to the full rule) and go to ACK.
  - ACK: rx_done=1 for exactly this cycle, then go to WAIT.
  - WAIT: stay while rx_rdy=1. Go to IDLE when rx_rdy=0. This guards against counting one byte twice if RS232R clears rdy late.
- rx_done is driven from a register. It is high only in the cycle the FSM is in ACK, which is the cycle after the push.
- Push with the FIFO full:
  - If rd=1 in the same cycle, the pop frees a slot and the push succeeds; count is unchanged.
  - Otherwise the byte is discarded, ovf is set to 1, and the FSM still goes to ACK so RS232R is released.
- Pop: rd=1 with count>0 advances rd_ptr and decrements count. rd=1 with count=0 is ignored: no pointer change and no error flag.
- Simultaneous push and pop with count>0: both pointers advance and count is unchanged.
- Simultaneous push and pop with count=0: the push lands and the pop is ignored, so count becomes 1.
- dout = mem[rd_ptr] when count>0, else 0. The value changes in the cycle after a pop. A byte is visible on dout the cycle after its push.
- ovf stays set until clr_ovf=1 or reset. If clr_ovf and an overflow occur in the same cycle, set wins and ovf=1.
- The CPU IO mux builds status word 3 as {28'b0, ovf, full, rdyTx, rdy}. rdyTx comes from the transmitter, not from this block.
- Latency: a byte on rx_data with rx_rdy rising at edge N is on dout with rdy=1 after edge N+1. rx_done is high during cycle N+1.

Optional Feature:
RX_FIFO_RTS_EN: when defined, adds output rts_n (1 bit) for hardware flow control. rts_n is registered and has hysteresis:
- It goes to 1 (stop sending) when count >= 2**AW-4.
- It returns to 0 when count <= 2**AW/2.
- Reset value is 0.
When the macro is undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
1. Single byte: rx_data=8'h41, rx_rdy high until rx_done. Expect rx_done high exactly 1 cycle, one cycle after the push; rdy=1, count=1, dout=8'h41. Then pulse rd: rdy=0, dout=0.
2. Fill and drain: 16 bytes 8'h00..8'h0F with no reads. Expect full=1, count=16, ovf=0. Then 16 rd pulses return 00..0F in order and wrap the pointers. A further 3 bytes 8'hA0..8'hA2 read back correctly, proving wrap-around.
3. Overflow: with the FIFO full, send 8'hEE and no rd. Expect rx_done still pulses, count stays 16, ovf=1, and the head byte is unchanged. Pulse clr_ovf: ovf=0. Clear and overflow in the same cycle: ovf=1.
4. Full with simultaneous rd: the push lands, count stays 16, and the last entry read out is the new byte.
5. Stuck rx_rdy: hold rx_rdy=1 for 10 cycles after rx_done. Expect exactly one push and the FSM in WAIT. Drop rx_rdy for 1 cycle: FSM returns to IDLE and the next rdy pushes again.
6. Reset mid-operation: assert rst=0 asynchronously with count=5 and the FSM in ACK. Outputs clear immediately (rx_done=0, rdy=0, count=0, ovf=0). After release, a single byte pushes normally. With RX_FIFO_RTS_EN defined: rts_n=1 at count 12 and returns to 0 at count 8.
